vga_grid_display: RTL and testbench

Parametrised successor to the battleship VGA path: a single-clock VGA timing generator plus pipelined renderer for `BOARDS` game boards of `ROWS`×`COLS` 4-bit cells, with frame-synchronous board capture and a blinking cursor. It sits between the game logic, which supplies the cell matrices and cursor, and the video DAC. The pixel clock is an external strobe `pix_en` from the PLL-domain divider, so everything runs on `clk`.

---
 rtl/vga_grid_display.sv | 236 +++++++++++++++++++++++
 tb/tb_vga_grid_display.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_grid_display.sv
// VGA timing plus three-stage board renderer.
// Shadowed cell/cursor capture at vblank start; blinking cursor.
module vga_grid_display #(
    parameter int H_ACTIVE     = 640,
    parameter int H_FP         = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BP         = 48,
    parameter int V_ACTIVE     = 480,
    parameter int V_FP         = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BP         = 33,
    parameter int ROWS         = 5,
    parameter int COLS         = 5,
    parameter int BOARDS       = 2,
    parameter int CELL_LOG2    = 5,
    parameter int BOARD_X0     = 96,
    parameter int BOARD_GAP    = 128,
    parameter int BOARD_Y0     = 160,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           pix_en,
    input  logic [BOARDS*ROWS*COLS*4-1:0]  cells,
    input  logic                           cursor_en,
    input  logic [$clog2(BOARDS)-1:0]      cursor_board,
    input  logic [$clog2(ROWS)-1:0]        cursor_row,
    input  logic [$clog2(COLS)-1:0]        cursor_col,
    output logic                           hsync,
    output logic                           vsync,
    output logic                           sync_b,
    output logic                           blank_b,
    output logic [7:0]                     r,
    output logic [7:0]                     g,
    output logic [7:0]                     b,
    output logic                           frame_start,
    output logic [9:0]                     x,
    output logic [9:0]                     y
);

    localparam int HT     = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT     = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_ON  = H_ACTIVE + H_FP;
    localparam int HS_OFF = HS_ON + H_SYNC;
    localparam int VS_ON  = V_ACTIVE + V_FP;
    localparam int VS_OFF = VS_ON + V_SYNC;
    localparam int CELL   = 1 << CELL_LOG2;
    localparam int BRD_W  = COLS * CELL;
    localparam int BRD_H  = ROWS * CELL;
    localparam int PITCH  = BRD_W + BOARD_GAP;
    localparam int BW     = $clog2(BOARDS);
    localparam int RW     = $clog2(ROWS);
    localparam int CW     = $clog2(COLS);
    localparam int NCELL  = BOARDS * ROWS * COLS;
    localparam int IW     = (NCELL > 1) ? $clog2(NCELL) : 1;
    localparam int CNTW   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic x_wrap, y_wrap, cap;

    logic [NCELL*4-1:0] sh_cells;
    logic               sh_cen;
    logic [BW-1:0]      sh_cb;
    logic [RW-1:0]      sh_cr;
    logic [CW-1:0]      sh_cc;
    logic [CNTW-1:0]    blink_cnt;
    logic               blink_ph;

    logic [11:0]          xe, ye, oy, ox_k;
    logic                 d_in_y, d_hit;
    logic [BW-1:0]        d_board;
    logic [RW-1:0]        d_row;
    logic [CW-1:0]        d_col;
    logic [CELL_LOG2-1:0] d_lx, d_ly;
    logic                 d_hs, d_vs, d_act;

    logic                 s1_hs, s1_vs, s1_act, s1_hit;
    logic [BW-1:0]        s1_board;
    logic [RW-1:0]        s1_row;
    logic [CW-1:0]        s1_col;
    logic [CELL_LOG2-1:0] s1_lx, s1_ly;

    logic [IW-1:0]  idx;
    logic [3:0]     code;
    logic           cur_hit, border;
    logic [23:0]    pix;

    assign x_wrap = (x == 10'(HT - 1));
    assign y_wrap = (y == 10'(VT - 1));
    assign cap    = pix_en && x_wrap && (y == 10'(V_ACTIVE - 1));

    // Stage 0: raster counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x <= '0;
            y <= '0;
        end else if (pix_en) begin
            x <= x_wrap ? 10'd0 : x + 10'd1;
            if (x_wrap)
                y <= y_wrap ? 10'd0 : y + 10'd1;
        end
    end

    // Vblank-start capture of board data, cursor and blink phase
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_start <= 1'b0;
            sh_cells    <= '0;
            sh_cen      <= 1'b0;
            sh_cb       <= '0;
            sh_cr       <= '0;
            sh_cc       <= '0;
            blink_cnt   <= '0;
            blink_ph    <= 1'b1;
        end else begin
            frame_start <= cap;
            if (cap) begin
                sh_cells <= cells;
                sh_cen   <= cursor_en;
                sh_cb    <= cursor_board;
                sh_cr    <= cursor_row;
                sh_cc    <= cursor_col;
                if (blink_cnt == CNTW'(BLINK_FRAMES - 1)) begin
                    blink_cnt <= '0;
                    blink_ph  <= ~blink_ph;
                end else begin
                    blink_cnt <= blink_cnt + CNTW'(1);
                end
            end
        end
    end

    // Stage 1 decode: which board/cell the counter sits in, plus sync/blank
    always_comb begin
        xe      = {2'b00, x};
        ye      = {2'b00, y};
        oy      = ye - 12'(BOARD_Y0);
        d_in_y  = (ye >= 12'(BOARD_Y0)) && (oy < 12'(BRD_H));
        d_hit   = 1'b0;
        d_board = '0;
        d_col   = '0;
        d_lx    = '0;
        ox_k    = '0;
        for (int k = 0; k < BOARDS; k++) begin
            ox_k = xe - 12'(BOARD_X0 + k * PITCH);
            if (d_in_y && xe >= 12'(BOARD_X0 + k * PITCH) &&
                ox_k < 12'(BRD_W)) begin
                d_hit   = 1'b1;
                d_board = BW'(k);
                d_col   = ox_k[CELL_LOG2 +: CW];
                d_lx    = ox_k[CELL_LOG2-1:0];
            end
        end
        d_row = oy[CELL_LOG2 +: RW];
        d_ly  = oy[CELL_LOG2-1:0];
        d_hs  = !(x >= 10'(HS_ON) && x < 10'(HS_OFF));
        d_vs  = !(y >= 10'(VS_ON) && y < 10'(VS_OFF));
        d_act = (x < 10'(H_ACTIVE)) && (y < 10'(V_ACTIVE));
    end

    // Stage 1 register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_hs    <= 1'b1;
            s1_vs    <= 1'b1;
            s1_act   <= 1'b0;
            s1_hit   <= 1'b0;
            s1_board <= '0;
            s1_row   <= '0;
            s1_col   <= '0;
            s1_lx    <= '0;
            s1_ly    <= '0;
        end else if (pix_en) begin
            s1_hs    <= d_hs;
            s1_vs    <= d_vs;
            s1_act   <= d_act;
            s1_hit   <= d_hit;
            s1_board <= d_board;
            s1_row   <= d_row;
            s1_col   <= d_col;
            s1_lx    <= d_lx;
            s1_ly    <= d_ly;
        end
    end

    // Stage 2 colour selection in priority order
    always_comb begin
        idx     = IW'((int'(s1_board) * ROWS + int'(s1_row)) * COLS
                      + int'(s1_col));
        code    = 4'(sh_cells >> {idx, 2'b00});
        cur_hit = sh_cen && blink_ph && (sh_cb == s1_board) &&
                  (sh_cr == s1_row) && (sh_cc == s1_col);
        border  = (s1_lx < CELL_LOG2'(2)) ||
                  (s1_lx >= CELL_LOG2'(CELL - 2)) ||
                  (s1_ly < CELL_LOG2'(2)) ||
                  (s1_ly >= CELL_LOG2'(CELL - 2));
        pix     = 24'h000000;
        if (!s1_act) begin
            pix = 24'h000000;
        end else if (s1_hit && cur_hit && border) begin
            pix = 24'hFFFF00;
        end else if (s1_hit && (s1_lx == '0 || s1_ly == '0)) begin
            pix = 24'h404040;
        end else if (s1_hit) begin
            case (code)
                4'd0:    pix = 24'h000080;
                4'd1:    pix = 24'h808080;
                4'd2:    pix = 24'hFF0000;
                4'd3:    pix = 24'hFFFFFF;
                4'd4:    pix = 24'h800000;
                default: pix = 24'hFF00FF;
            endcase
        end
    end

    // Stage 2 output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync   <= 1'b1;
            vsync   <= 1'b1;
            sync_b  <= 1'b1;
            blank_b <= 1'b0;
            r       <= '0;
            g       <= '0;
            b       <= '0;
        end else if (pix_en) begin
            hsync   <= s1_hs;
            vsync   <= s1_vs;
            sync_b  <= s1_hs & s1_vs;
            blank_b <= s1_act;
            r       <= pix[23:16];
            g       <= pix[15:8];
            b       <= pix[7:0];
        end
    end

endmodule

// File: tb/tb_vga_grid_display.sv
// Directed bench for vga_grid_display on a shrunken raster.
// Pixel table plus timing, tearing, stall, reset and blink sequences.
module tb_vga_grid_display;

    localparam int H_ACTIVE = 80, H_FP = 4, H_SYNC = 8, H_BP = 4;
    localparam int V_ACTIVE = 40, V_FP = 2, V_SYNC = 2, V_BP = 4;
    localparam int HT = 96, VT = 48;
    localparam int ROWS = 3, COLS = 4, BOARDS = 2, CELL_LOG2 = 3;
    localparam int BOARD_X0 = 4, BOARD_GAP = 4, BOARD_Y0 = 8;
    localparam int BLINK_FRAMES = 2;
    localparam int NB = BOARDS * ROWS * COLS * 4;
    localparam int LIMIT = HT * VT + 10;

    logic          clk, rst, pix_en;
    logic [NB-1:0] cells;
    logic          cursor_en;
    logic [0:0]    cursor_board;
    logic [1:0]    cursor_row, cursor_col;
    logic          hsync, vsync, sync_b, blank_b, frame_start;
    logic [7:0]    r, g, b;
    logic [9:0]    x, y;

    vga_grid_display #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .ROWS(ROWS), .COLS(COLS), .BOARDS(BOARDS), .CELL_LOG2(CELL_LOG2),
        .BOARD_X0(BOARD_X0), .BOARD_GAP(BOARD_GAP), .BOARD_Y0(BOARD_Y0),
        .BLINK_FRAMES(BLINK_FRAMES)
    ) dut (
        .clk(clk), .rst(rst), .pix_en(pix_en), .cells(cells),
        .cursor_en(cursor_en), .cursor_board(cursor_board),
        .cursor_row(cursor_row), .cursor_col(cursor_col),
        .hsync(hsync), .vsync(vsync), .sync_b(sync_b), .blank_b(blank_b),
        .r(r), .g(g), .b(b), .frame_start(frame_start), .x(x), .y(y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit fast = 1'b1;
    int fs_seen = 0;

    always @(negedge clk) if (frame_start) fs_seen++;

    typedef struct {
        int          px;
        int          py;
        logic [23:0] rgb;
        logic        bl;
        logic        hs;
        logic        vs;
    } vec_t;

    vec_t tbl[19];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        pix_en = 1'b1;
        @(negedge clk);
        pix_en = 1'b0;
        if (!fast) @(negedge clk);
    endtask

    task automatic goto(input int tx, input int ty);
        int n;
        n = 0;
        while (!(x == tx && y == ty) && n < LIMIT) begin
            tick();
            n++;
        end
        if (n >= LIMIT) begin
            checks++;
            errors++;
            $display("FAIL goto(%0d,%0d): got timeout expected arrival",
                     tx, ty);
        end
    endtask

    task automatic pixel(input string name, input int px, input int py,
                         input logic [23:0] exp);
        goto(px, py);
        tick();
        tick();
        chk(name, {blank_b, r, g, b}, {1'b1, exp});
    endtask

    task automatic set_cell(input int k, input int rr, input int cc,
                            input int v);
        cells[((k * ROWS + rr) * COLS + cc) * 4 +: 4] = 4'(v);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int mx, my, bad_xy, hs_low, vs_low, bl_cnt, falls, bad_per;
        int fall_x, last_fall, vs_fx, vs_fy, fs0, stall_bad;
        logic prev_hs, prev_vs;
        logic [23:0] exp_rgb;

        tbl[0]  = '{2, 2, 24'h000000, 1, 1, 1};
        tbl[1]  = '{40, 8, 24'h404040, 1, 1, 1};
        tbl[2]  = '{4, 9, 24'h404040, 1, 1, 1};
        tbl[3]  = '{6, 10, 24'hFF0000, 1, 1, 1};
        tbl[4]  = '{14, 10, 24'h808080, 1, 1, 1};
        tbl[5]  = '{22, 11, 24'h800000, 1, 1, 1};
        tbl[6]  = '{30, 11, 24'hFF00FF, 1, 1, 1};
        tbl[7]  = '{36, 11, 24'h000000, 1, 1, 1};
        tbl[8]  = '{6, 16, 24'h404040, 1, 1, 1};
        tbl[9]  = '{7, 18, 24'h000080, 1, 1, 1};
        tbl[10] = '{38, 20, 24'h000000, 1, 1, 1};
        tbl[11] = '{58, 20, 24'hFFFFFF, 1, 1, 1};
        tbl[12] = '{71, 21, 24'h000080, 1, 1, 1};
        tbl[13] = '{72, 22, 24'h000000, 1, 1, 1};
        tbl[14] = '{81, 22, 24'h000000, 0, 1, 1};
        tbl[15] = '{86, 22, 24'h000000, 0, 0, 1};
        tbl[16] = '{10, 32, 24'h000000, 1, 1, 1};
        tbl[17] = '{5, 41, 24'h000000, 0, 1, 1};
        tbl[18] = '{10, 42, 24'h000000, 0, 1, 0};

        rst = 1'b1;
        pix_en = 1'b0;
        cells = '0;
        cursor_en = 1'b0;
        cursor_board = '0;
        cursor_row = '0;
        cursor_col = '0;
        repeat (3) @(negedge clk);

        chk("reset_xy", {x, y}, 32'h0);
        chk("reset_out", {hsync, vsync, sync_b, blank_b, r, g, b, frame_start},
            {4'b1110, 24'h0, 1'b0});
        rst = 1'b0;
        @(negedge clk);

        set_cell(0, 0, 0, 2);
        set_cell(0, 0, 1, 1);
        set_cell(0, 0, 2, 4);
        set_cell(0, 0, 3, 9);
        set_cell(1, 1, 2, 3);

        goto(0, V_ACTIVE);
        chk("frame_start_pulse", frame_start, 1);

        for (int i = 0; i < 19; i++) begin
            goto(tbl[i].px, tbl[i].py);
            tick();
            tick();
            chk($sformatf("vec%0d(%0d,%0d)", i, tbl[i].px, tbl[i].py),
                {blank_b, hsync, vsync, sync_b, r, g, b},
                {tbl[i].bl, tbl[i].hs, tbl[i].vs, tbl[i].hs & tbl[i].vs,
                 tbl[i].rgb});
        end

        fast = 1'b0;
        goto(0, 0);
        mx = 0; my = 0; bad_xy = 0; hs_low = 0; vs_low = 0; bl_cnt = 0;
        falls = 0; bad_per = 0; fall_x = -1; last_fall = -1;
        vs_fx = -1; vs_fy = -1;
        prev_hs = hsync;
        prev_vs = vsync;
        fs0 = fs_seen;
        for (int i = 1; i <= HT * VT; i++) begin
            tick();
            mx++;
            if (mx == HT) begin
                mx = 0;
                my++;
                if (my == VT) my = 0;
            end
            if (x != mx || y != my) bad_xy++;
            if (!hsync) hs_low++;
            if (!vsync) vs_low++;
            if (blank_b) bl_cnt++;
            if (prev_hs && !hsync) begin
                falls++;
                if (fall_x < 0) fall_x = int'(x);
                if (last_fall >= 0 && i - last_fall != HT) bad_per++;
                last_fall = i;
            end
            if (prev_vs && !vsync && vs_fx < 0) begin
                vs_fx = int'(x);
                vs_fy = int'(y);
            end
            prev_hs = hsync;
            prev_vs = vsync;
        end
        chk("counter_model", bad_xy, 0);
        chk("hsync_low_total", hs_low, 8 * VT);
        chk("hsync_fall_x", fall_x, 86);
        chk("hsync_falls", falls, VT);
        chk("line_period", bad_per, 0);
        chk("vsync_low_total", vs_low, 2 * HT);
        chk("vsync_fall_xy", {vs_fx[15:0], vs_fy[15:0]}, {16'd2, 16'd42});
        chk("blank_total", bl_cnt, H_ACTIVE * V_ACTIVE);
        chk("frame_start_per_frame", fs_seen - fs0, 1);

        fast = 1'b1;
        goto(0, 12);
        set_cell(1, 1, 2, 4);
        set_cell(0, 2, 0, 1);
        pixel("tear_old_b1", 58, 20, 24'hFFFFFF);
        pixel("tear_old_b0", 6, 26, 24'h000080);
        pixel("tear_new_b1", 58, 20, 24'h800000);
        pixel("tear_new_b0", 6, 26, 24'h808080);

        goto(50, 30);
        stall_bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (x != 10'd50 || y != 10'd30 || {r, g, b} != 24'h404040 ||
                !blank_b || !hsync || !vsync || frame_start)
                stall_bad++;
        end
        chk("stall_hold", stall_bad, 0);
        tick();
        chk("stall_resume", {x, r, g, b}, {10'd51, 24'h000080});

        goto(70, 30);
        tick();
        tick();
        chk("pre_reset_pixel", {r, g, b}, 24'h000080);
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset_xy", {x, y}, 32'h0);
        chk("async_reset_out",
            {hsync, vsync, sync_b, blank_b, r, g, b, frame_start},
            {4'b1110, 24'h0, 1'b0});
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("post_reset_strobe1", {x, blank_b}, {10'd1, 1'b0});
        tick();
        chk("post_reset_strobe2", {x, y, blank_b, r, g, b},
            {10'd2, 10'd0, 1'b1, 24'h0});

        cursor_en = 1'b1;
        cursor_board = 1'b0;
        cursor_row = 2'd1;
        cursor_col = 2'd1;
        for (int f = 0; f < 5; f++) begin
            exp_rgb = (f == 1 || f == 4) ? 24'hFFFF00 : 24'h000080;
            pixel($sformatf("blink_border_f%0d", f), 13, 17, exp_rgb);
            pixel($sformatf("blink_interior_f%0d", f), 15, 19, 24'h000080);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
